l1_set_array: RTL and testbench

// - Tag/data storage and lookup engine for the L1 data cache: 64 sets x 8 ways x 64-byte lines, 24-bit tags.
// - The L1 controller drives one request per enable pulse: read, write, or fill (force_write).
// - Returns hit data or hit/miss status. The controller handles forwarding to lower levels.
// - Write-through, no-write-allocate: lines are allocated only by fills; no dirty state, no writeback port.

---
 rtl/l1_set_array.sv | 190 +++++++++++++++++++
 tb/tb_l1_set_array.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/l1_set_array.sv
// L1 data-cache tag/data set array: NUM_SETS x NUM_WAYS lines of LINE_BYTES bytes.
// One request per accepted enable; all results are registered and held until the
// next accepted request. Write-through, no-write-allocate: only fills allocate.
// Optional build macro SET_DEBUG_EN: print a trace line for every accepted op.
module l1_set_array #(
  parameter int unsigned NUM_SETS   = 64,
  parameter int unsigned NUM_WAYS   = 8,
  parameter int unsigned LINE_BYTES = 64,
  parameter int unsigned TAG_W      = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       enable,
  input  logic [1:0]       write_enable,
  input  logic [5:0]       block_offset,
  input  logic [5:0]       set_idx,
  input  logic [63:0]      write_data,
  input  logic [2:0]       write_size,
  input  logic [TAG_W-1:0] tag,
  input  logic [31:0]      nops,
  output logic [127:0]     data_out,
  output logic [1:0]       miss_w,
  output logic [1:0]       miss_r,
  output logic [1:0]       data_ready,
  input  logic [1:0]       force_write,
  output logic [1:0]       op_done
);

  localparam int unsigned SetW  = $clog2(NUM_SETS);
  localparam int unsigned WayW  = $clog2(NUM_WAYS);
  localparam int unsigned LineW = LINE_BYTES * 8;
  localparam int unsigned IdxW  = SetW + WayW;

  // Storage is never reset; only the valid bits gate its use.
  logic [LineW-1:0] data_mem [NUM_SETS*NUM_WAYS];
  logic [TAG_W-1:0] tag_mem  [NUM_SETS*NUM_WAYS];

  logic [NUM_SETS-1:0][NUM_WAYS-1:0] valid_q, valid_d;
  logic [NUM_SETS-1:0][WayW-1:0]     rr_q, rr_d;

  logic [127:0] data_out_q, data_out_d;
  logic         miss_w_q, miss_w_d;
  logic         miss_r_q, miss_r_d;
  logic         data_ready_q, data_ready_d;
  logic         op_done_q, op_done_d;

  logic            accept, is_fill, is_write;
  logic [SetW-1:0] set;
  logic            hit, inv_found, alloc, do_write;
  logic [WayW-1:0] hit_way, victim, tgt_way;
  logic [IdxW-1:0] hit_idx, wr_idx;
  logic [4:0]      rd_n;
  logic [3:0]      wr_n;
  logic [15:0]     rd_bmask;
  logic [7:0]      wr_bmask;
  logic [127:0]    rd_bitmask, rd_data;
  logic [LINE_BYTES-1:0] wr_line_bmask;
  logic [LineW-1:0]      wr_line_bitmask, wr_line, old_line, new_line;

  // Request decode, tag lookup, victim choice and byte-lane masks.
  always_comb begin
    accept   = (enable != 2'b00) && !rst;
    is_fill  = force_write != 2'b00;
    is_write = !is_fill && (write_enable != 2'b00);
    set      = set_idx[SetW-1:0];

    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[set][w] && (tag_mem[{set, WayW'(w)}] == tag)) begin
        hit     = 1'b1;
        hit_way = WayW'(w);
      end
    end

    // Lowest invalid way wins; otherwise fall back to the round-robin pointer.
    inv_found = 1'b0;
    victim    = rr_q[set];
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_q[set][w]) begin
        inv_found = 1'b1;
        victim    = WayW'(w);
      end
    end

    tgt_way  = hit ? hit_way : victim;
    alloc    = accept && is_fill && !hit;
    do_write = accept && (is_fill || (is_write && hit));
    hit_idx  = {set, hit_way};
    wr_idx   = {set, tgt_way};

    // Reads clamp to 16 bytes, writes/fills to 8.
    rd_n = (write_size >= 3'd4) ? 5'd16 : 5'(5'd1 << write_size);
    wr_n = (write_size >= 3'd3) ? 4'd8 : 4'(4'd1 << write_size);
    rd_bmask = 16'((17'd1 << rd_n) - 17'd1);
    wr_bmask = 8'((9'd1 << wr_n) - 9'd1);

    for (int b = 0; b < 16; b++) rd_bitmask[b*8 +: 8] = {8{rd_bmask[b]}};
    // Bytes shifted past the line end fall off: no wrap on read or write.
    rd_data = 128'(data_mem[hit_idx] >> {block_offset, 3'b000}) & rd_bitmask;

    wr_line_bmask = LINE_BYTES'(wr_bmask) << block_offset;
    for (int b = 0; b < LINE_BYTES; b++) wr_line_bitmask[b*8 +: 8] = {8{wr_line_bmask[b]}};
    wr_line  = LineW'(write_data) << {block_offset, 3'b000};
    // A freshly allocated line starts from all-zero bytes.
    old_line = alloc ? '0 : data_mem[wr_idx];
    new_line = (old_line & ~wr_line_bitmask) | (wr_line & wr_line_bitmask);
  end

  // Next-state for valid bits, round-robin pointers and the sticky outputs.
  always_comb begin
    valid_d      = valid_q;
    rr_d         = rr_q;
    data_out_d   = data_out_q;
    miss_w_d     = miss_w_q;
    miss_r_d     = miss_r_q;
    data_ready_d = data_ready_q;
    op_done_d    = op_done_q;
    if (accept) begin
      data_out_d   = '0;
      miss_w_d     = 1'b0;
      miss_r_d     = 1'b0;
      data_ready_d = 1'b0;
      op_done_d    = 1'b1;
      if (is_fill) begin
        if (!hit) begin
          valid_d[set][victim] = 1'b1;
          if (!inv_found) rr_d[set] = rr_q[set] + WayW'(1);
        end
      end else if (is_write) begin
        miss_w_d = !hit;
      end else if (hit) begin
        data_ready_d = 1'b1;
        data_out_d   = rd_data;
      end else begin
        miss_r_d = 1'b1;
      end
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= '0;
      rr_q         <= '0;
      data_out_q   <= '0;
      miss_w_q     <= 1'b0;
      miss_r_q     <= 1'b0;
      data_ready_q <= 1'b0;
      op_done_q    <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      rr_q         <= rr_d;
      data_out_q   <= data_out_d;
      miss_w_q     <= miss_w_d;
      miss_r_q     <= miss_r_d;
      data_ready_q <= data_ready_d;
      op_done_q    <= op_done_d;
    end
  end

  // Tag and data array writes (hit updates and fills).
  always_ff @(posedge clk) begin
    if (do_write) begin
      if (alloc) tag_mem[wr_idx] <= tag;
      data_mem[wr_idx] <= new_line;
    end
  end

  assign data_out   = data_out_q;
  assign miss_w     = {1'b0, miss_w_q};
  assign miss_r     = {1'b0, miss_r_q};
  assign data_ready = {1'b0, data_ready_q};
  assign op_done    = {1'b0, op_done_q};

`ifdef SET_DEBUG_EN
  // Trace each accepted op with its lookup result.
  always_ff @(posedge clk) begin
    if (accept) begin
      $display("[l1_set_array] op=%0d %s set=%0d tag=%h off=%0d %s way=%0d wdata=%h rdata=%h",
               nops, is_fill ? "FILL" : (is_write ? "WRITE" : "READ"), set, tag,
               block_offset, hit ? "hit" : "miss", tgt_way, write_data, rd_data);
    end
  end
`else
  logic unused_nops;
  assign unused_nops = ^nops;
`endif

endmodule

// File: tb/tb_l1_set_array.sv
// Scoreboard bench for l1_set_array: the driver queues the expected registered
// response for every accepted op or reset cycle; a monitor checks it a half cycle later.
module tb_l1_set_array;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [1:0]   enable = '0, write_enable = '0, force_write = '0;
  logic [5:0]   block_offset = '0, set_idx = '0;
  logic [63:0]  write_data = '0;
  logic [2:0]   write_size = '0;
  logic [23:0]  tag = '0;
  logic [31:0]  nops = '0;
  logic [127:0] data_out;
  logic [1:0]   miss_w, miss_r, data_ready, op_done;

  always #5 clk = ~clk;

  l1_set_array dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .write_enable (write_enable),
    .block_offset (block_offset),
    .set_idx      (set_idx),
    .write_data   (write_data),
    .write_size   (write_size),
    .tag          (tag),
    .nops         (nops),
    .data_out     (data_out),
    .miss_w       (miss_w),
    .miss_r       (miss_r),
    .data_ready   (data_ready),
    .force_write  (force_write),
    .op_done      (op_done)
  );

  typedef struct packed {
    logic [127:0] d;
    logic         mw, mr, dr, od;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  bit    pend    = 1'b0;

  // An output update is due after every edge that sees reset or a request.
  always @(posedge clk) pend <= rst || (enable != 2'b00);

  // Monitor: compare registered outputs against the oldest expectation.
  always @(negedge clk) begin
    if (pend) begin
      exp_t  e;
      string nm;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_update: DUT updated outputs with no expectation queued");
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (data_out !== e.d || miss_w !== {1'b0, e.mw} || miss_r !== {1'b0, e.mr} ||
            data_ready !== {1'b0, e.dr} || op_done !== {1'b0, e.od}) begin
          n_fail++;
          $display("FAIL %s: got d=%h mw=%b mr=%b dr=%b od=%b, want d=%h mw=%b mr=%b dr=%b od=%b",
                   nm, data_out, miss_w, miss_r, data_ready, op_done,
                   e.d, e.mw, e.mr, e.dr, e.od);
        end
      end
    end
  end

  function automatic exp_t x_rd(input logic [127:0] d);
    x_rd = '{d: d, mw: 1'b0, mr: 1'b0, dr: 1'b1, od: 1'b1};
  endfunction
  function automatic exp_t x_done();
    x_done = '{d: '0, mw: 1'b0, mr: 1'b0, dr: 1'b0, od: 1'b1};
  endfunction
  function automatic exp_t x_mr();
    x_mr = '{d: '0, mw: 1'b0, mr: 1'b1, dr: 1'b0, od: 1'b1};
  endfunction
  function automatic exp_t x_mw();
    x_mw = '{d: '0, mw: 1'b1, mr: 1'b0, dr: 1'b0, od: 1'b1};
  endfunction
  function automatic exp_t x_zero();
    x_zero = '{d: '0, mw: 1'b0, mr: 1'b0, dr: 1'b0, od: 1'b0};
  endfunction

  task automatic issue(input string nm, input bit fw, input bit we, input logic [5:0] s,
                       input logic [23:0] t, input logic [5:0] off, input logic [2:0] sz,
                       input logic [63:0] wd, input exp_t e);
    @(negedge clk);
    rst          = 1'b0;
    enable       = 2'b01;
    force_write  = {1'b0, fw};
    write_enable = {1'b0, we};
    set_idx      = s;
    tag          = t;
    block_offset = off;
    write_size   = sz;
    write_data   = wd;
    nops         = nops + 32'd1;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic rd(input string nm, input logic [5:0] s, input logic [23:0] t,
                    input logic [5:0] off, input logic [2:0] sz, input exp_t e);
    issue(nm, 1'b0, 1'b0, s, t, off, sz, 64'h0, e);
  endtask
  task automatic wr(input string nm, input logic [5:0] s, input logic [23:0] t,
                    input logic [5:0] off, input logic [2:0] sz, input logic [63:0] wd,
                    input exp_t e);
    issue(nm, 1'b0, 1'b1, s, t, off, sz, wd, e);
  endtask
  task automatic fill(input string nm, input logic [5:0] s, input logic [23:0] t,
                      input logic [5:0] off, input logic [2:0] sz, input logic [63:0] wd);
    issue(nm, 1'b1, 1'b0, s, t, off, sz, wd, x_done());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst    = 1'b0;
      enable = 2'b00;
    end
  endtask

  // Reset cycle, optionally colliding with a fill request that must be dropped.
  task automatic do_rst(input string nm, input bit with_fill);
    @(negedge clk);
    rst          = 1'b1;
    enable       = with_fill ? 2'b01 : 2'b00;
    force_write  = with_fill ? 2'b01 : 2'b00;
    write_enable = 2'b00;
    set_idx      = 6'd9;
    tag          = 24'h000077;
    block_offset = 6'd0;
    write_size   = 3'd3;
    write_data   = 64'hDEADBEEFCAFEF00D;
    exp_q.push_back(x_zero());
    name_q.push_back(nm);
  endtask

  initial begin
    do_rst("reset0", 1'b0);
    do_rst("reset1", 1'b0);

    // Basic miss, fill, hit, partial write, write miss.
    rd("rd_cold_miss", 6'd3, 24'h000ABC, 6'd8, 3'd3, x_mr());
    fill("fill_s3", 6'd3, 24'h000ABC, 6'd8, 3'd3, 64'h1122334455667788);
    rd("rd_after_fill", 6'd3, 24'h000ABC, 6'd8, 3'd3, x_rd(128'h1122334455667788));
    wr("wr_hit_byte", 6'd3, 24'h000ABC, 6'd8, 3'd0, 64'h00000000000000FF, x_done());
    rd("rd_after_wr", 6'd3, 24'h000ABC, 6'd8, 3'd3, x_rd(128'h11223344556677FF));
    wr("wr_miss", 6'd3, 24'h000ABD, 6'd8, 3'd3, 64'h0123456789ABCDEF, x_mw());
    rd("rd_unchanged", 6'd3, 24'h000ABC, 6'd8, 3'd3, x_rd(128'h11223344556677FF));
    // 16-byte read: bytes 16..23 were zeroed by allocation.
    rd("rd_16B", 6'd3, 24'h000ABC, 6'd8, 3'd4, x_rd(128'h0000000000000000_11223344556677FF));
    rd("rd_zeroed", 6'd3, 24'h000ABC, 6'd0, 3'd3, x_rd(128'h0));

    // Nine fills in set 5: way 0 (tag 1) is evicted by tag 9.
    for (int t = 1; t <= 9; t++)
      fill($sformatf("fill5_t%0d", t), 6'd5, 24'(t), 6'd0, 3'd3, 64'(t));
    rd("rd5_evicted_t1", 6'd5, 24'd1, 6'd0, 3'd3, x_mr());
    for (int t = 2; t <= 9; t++)
      rd($sformatf("rd5_t%0d", t), 6'd5, 24'(t), 6'd0, 3'd3, x_rd(128'(t)));
    // Pointer has advanced: next victim is way 1 (tag 2).
    fill("fill5_t10", 6'd5, 24'd10, 6'd0, 3'd3, 64'd10);
    rd("rd5_evicted_t2", 6'd5, 24'd2, 6'd0, 3'd3, x_mr());
    rd("rd5_t10", 6'd5, 24'd10, 6'd0, 3'd3, x_rd(128'd10));
    rd("rd5_t3_kept", 6'd5, 24'd3, 6'd0, 3'd3, x_rd(128'd3));

    // Line-end behaviour and size clamping in set 7.
    fill("fill7_end", 6'd7, 24'h000055, 6'd56, 3'd3, 64'hAAAAAAAAAAAAAAAA);
    rd("rd7_past_end", 6'd7, 24'h000055, 6'd60, 3'd3, x_rd(128'hAAAAAAAA));
    wr("wr7_clamp8", 6'd7, 24'h000055, 6'd0, 3'd7, 64'h0102030405060708, x_done());
    rd("rd7_clamp16", 6'd7, 24'h000055, 6'd0, 3'd7, x_rd(128'h0102030405060708));
    fill("fill7_hit_edge", 6'd7, 24'h000055, 6'd62, 3'd3, 64'h1122334455667788);
    rd("rd7_edge", 6'd7, 24'h000055, 6'd56, 3'd3, x_rd(128'h7788AAAAAAAAAAAA));
    rd("rd7_hit_fill_kept", 6'd7, 24'h000055, 6'd0, 3'd3, x_rd(128'h0102030405060708));

    // Reset collides with a fill; everything is invalidated.
    do_rst("reset_with_fill", 1'b1);
    rd("rd9_after_rst", 6'd9, 24'h000077, 6'd0, 3'd3, x_mr());
    rd("rd3_after_rst", 6'd3, 24'h000ABC, 6'd8, 3'd3, x_mr());

    // force_write without enable is ignored.
    @(negedge clk);
    enable      = 2'b00;
    force_write = 2'b01;
    set_idx     = 6'd9;
    tag         = 24'h000077;
    rd("rd9_no_enable_fill", 6'd9, 24'h000077, 6'd0, 3'd3, x_mr());

    idle(2);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expected responses never appeared, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
